piano_key_scan: RTL and testbench

PIANO_KEY_SCAN -- requirements
Module: piano_key_scan

---
 rtl/piano_key_scan.sv | 128 ++++++++++++
 tb/tb_piano_key_scan.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/piano_key_scan.sv
// Twelve-key debounced keyboard scanner: picks the lowest pressed key and
// emits its tone-divider half period plus a change pulse for the tone generator.
module piano_key_scan #(
  parameter int unsigned TICK_DIV = 50000,
  parameter int unsigned DEB_CNT  = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] keys,
  output logic        note_on,
  output logic [3:0]  note_idx,
  output logic [18:0] half_period,
  output logic        note_change
);

  localparam int unsigned NKEYS  = 12;
  localparam int unsigned TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned CNT_W  = (DEB_CNT > 1) ? $clog2(DEB_CNT) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(DEB_CNT - 1);

  logic [NKEYS-1:0]  sync1;
  logic [NKEYS-1:0]  sync2;
  logic [NKEYS-1:0]  deb;
  logic [CNT_W-1:0]  bounce [NKEYS];
  logic [TICK_W-1:0] tick_cnt;
  logic              tick_c;
  logic              sel_on_c;
  logic [3:0]        sel_idx_c;
  logic [18:0]       sel_half_c;

  // Two-flop synchronizer for the raw buttons
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= keys;
      sync2 <= sync1;
    end
  end

  // Sample-tick generator
  assign tick_c = (tick_cnt == TICK_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      tick_cnt <= '0;
    end else if (tick_c) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + TICK_W'(1);
    end
  end

  // Per-key debounce: any sample matching the stable state restarts the count
  always_ff @(posedge clk) begin
    if (rst) begin
      deb <= '0;
      for (int i = 0; i < int'(NKEYS); i++) begin
        bounce[i] <= '0;
      end
    end else if (tick_c) begin
      for (int i = 0; i < int'(NKEYS); i++) begin
        if (sync2[i] == deb[i]) begin
          bounce[i] <= '0;
        end else if (bounce[i] == CNT_LAST) begin
          deb[i]    <= sync2[i];
          bounce[i] <= '0;
        end else begin
          bounce[i] <= bounce[i] + CNT_W'(1);
        end
      end
    end
  end

  // Fixed priority: lowest pressed index wins
  always_comb begin
    sel_on_c  = 1'b0;
    sel_idx_c = '0;
    for (int i = int'(NKEYS) - 1; i >= 0; i--) begin
      if (deb[i]) begin
        sel_on_c  = 1'b1;
        sel_idx_c = 4'(i);
      end
    end
  end

  // Half-period table, C4 through B4
  always_comb begin
    sel_half_c = '0;
    case (sel_idx_c)
      4'd0:    sel_half_c = 19'd95554;
      4'd1:    sel_half_c = 19'd90193;
      4'd2:    sel_half_c = 19'd85131;
      4'd3:    sel_half_c = 19'd80351;
      4'd4:    sel_half_c = 19'd75842;
      4'd5:    sel_half_c = 19'd71585;
      4'd6:    sel_half_c = 19'd67566;
      4'd7:    sel_half_c = 19'd63775;
      4'd8:    sel_half_c = 19'd60196;
      4'd9:    sel_half_c = 19'd56817;
      4'd10:   sel_half_c = 19'd53629;
      4'd11:   sel_half_c = 19'd50618;
      default: sel_half_c = '0;
    endcase
    if (!sel_on_c) begin
      sel_half_c = '0;
    end
  end

  // Registered outputs; the pulse flags any difference against the held values
  always_ff @(posedge clk) begin
    if (rst) begin
      note_on     <= 1'b0;
      note_idx    <= '0;
      half_period <= '0;
      note_change <= 1'b0;
    end else begin
      note_on     <= sel_on_c;
      note_idx    <= sel_idx_c;
      half_period <= sel_half_c;
      note_change <= (sel_on_c != note_on) || (sel_idx_c != note_idx) ||
                     (sel_half_c != half_period);
    end
  end

endmodule

// File: tb/tb_piano_key_scan.sv
// Bench for piano_key_scan: directed scenarios plus random key traffic,
// all checked cycle by cycle against a time-indexed behavioural model.
module tb_piano_key_scan;

  localparam int TICK_DIV = 4;
  localparam int DEB_CNT  = 3;
  localparam int unsigned HALF_TAB [12] = '{95554, 90193, 85131, 80351, 75842, 71585,
                                           67566, 63775, 60196, 56817, 53629, 50618};

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [11:0] keys = 12'h000;
  logic        note_on;
  logic [3:0]  note_idx;
  logic [18:0] half_period;
  logic        note_change;

  int total = 0;
  int bad   = 0;

  // Model state: cycles since reset release, last two raw key samples,
  // stable key states and consecutive-disagreement run lengths
  int          mcyc;
  logic [11:0] kpipe [$];
  logic [11:0] mdeb;
  int          mrun [12];
  logic        exp_on;
  logic [3:0]  exp_idx;
  logic [18:0] exp_half;
  logic        exp_chg;

  piano_key_scan #(.TICK_DIV(TICK_DIV), .DEB_CNT(DEB_CNT)) dut (
    .clk(clk), .rst(rst), .keys(keys), .note_on(note_on), .note_idx(note_idx),
    .half_period(half_period), .note_change(note_change)
  );

  always #5 clk = ~clk;

  function automatic logic [23:0] encode(input logic [11:0] d);
    for (int i = 0; i < 12; i++) begin
      if (d[i]) return {1'b1, 4'(i), 19'(HALF_TAB[i])};
    end
    return 24'h0;
  endfunction

  // Advance one clock and the model with it; returns at the following falling edge
  task automatic step();
    logic [23:0] nxt;
    logic [11:0] smp;
    @(posedge clk);
    if (rst) begin
      kpipe.delete();
      mcyc = 0;
      mdeb = 12'h000;
      foreach (mrun[i]) mrun[i] = 0;
      {exp_on, exp_idx, exp_half} = 24'h0;
      exp_chg = 1'b0;
    end else begin
      nxt = encode(mdeb);
      exp_chg = (nxt != {exp_on, exp_idx, exp_half});
      {exp_on, exp_idx, exp_half} = nxt;
      smp = (kpipe.size() == 2) ? kpipe[0] : 12'h000;
      if (mcyc % TICK_DIV == TICK_DIV - 1) begin
        for (int i = 0; i < 12; i++) begin
          if (smp[i] != mdeb[i]) begin
            mrun[i]++;
            if (mrun[i] == DEB_CNT) begin
              mdeb[i] = smp[i];
              mrun[i] = 0;
            end
          end else begin
            mrun[i] = 0;
          end
        end
      end
      kpipe.push_back(keys);
      if (kpipe.size() > 2) void'(kpipe.pop_front());
      mcyc++;
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst  = 1'b1;
    keys = 12'($urandom);
    step();
    step();
    total++;
    if ({note_on, note_idx, half_period, note_change} !== 25'h0) begin
      bad++;
      $display("FAIL reset_outputs: got %h want 0", {note_on, note_idx, half_period, note_change});
    end
    rst = 1'b0;
    step();
    total++;
    if (note_change !== 1'b0) begin
      bad++;
      $display("FAIL reset_first_cycle: note_change got %b want 0", note_change);
    end
  endtask

  task automatic test_held();
    int pulses = 0;
    do_reset();
    keys = 12'h400;
    for (int c = 0; c < 20; c++) begin
      step();
      total++;
      if ({note_on, note_idx, half_period, note_change} !== {exp_on, exp_idx, exp_half, exp_chg}) begin
        bad++;
        $display("FAIL held_model c=%0d: got %h want %h", c,
                 {note_on, note_idx, half_period, note_change}, {exp_on, exp_idx, exp_half, exp_chg});
      end
      if (note_change) pulses++;
      // third tick lands on edge 11, outputs one edge later
      if (c == 11) begin
        total++;
        if (note_on !== 1'b0) begin
          bad++;
          $display("FAIL held_early: note_on got %b want 0", note_on);
        end
      end
    end
    total++;
    if ({note_on, note_idx, half_period} !== {1'b1, 4'd10, 19'd53629} || pulses != 1) begin
      bad++;
      $display("FAIL held_final: got on=%b idx=%0d half=%0d pulses=%0d want 1/10/53629/1",
               note_on, note_idx, half_period, pulses);
    end
  endtask

  task automatic test_glitch();
    int pulses = 0;
    do_reset();
    keys = 12'h001;
    for (int c = 0; c < 36; c++) begin
      step();
      if (c == 7) keys = 12'h000;
      total++;
      if ({note_on, note_idx, half_period, note_change} !== {exp_on, exp_idx, exp_half, exp_chg}) begin
        bad++;
        $display("FAIL glitch_model c=%0d: got %h want %h", c,
                 {note_on, note_idx, half_period, note_change}, {exp_on, exp_idx, exp_half, exp_chg});
      end
      if (note_change || note_on) pulses++;
    end
    total++;
    if (pulses != 0) begin
      bad++;
      $display("FAIL glitch_quiet: active cycles got %0d want 0", pulses);
    end
  endtask

  task automatic test_switch();
    int pulses = 0;
    int drops = 0;
    do_reset();
    keys = 12'h201;
    repeat (24) step();
    total++;
    if ({note_on, note_idx, half_period} !== {1'b1, 4'd0, 19'd95554}) begin
      bad++;
      $display("FAIL switch_pair: got on=%b idx=%0d half=%0d want 1/0/95554", note_on, note_idx, half_period);
    end
    keys = 12'h200;
    for (int c = 0; c < 24; c++) begin
      step();
      total++;
      if ({note_on, note_idx, half_period, note_change} !== {exp_on, exp_idx, exp_half, exp_chg}) begin
        bad++;
        $display("FAIL switch_model c=%0d: got %h want %h", c,
                 {note_on, note_idx, half_period, note_change}, {exp_on, exp_idx, exp_half, exp_chg});
      end
      if (note_change) pulses++;
      if (!note_on) drops++;
    end
    total++;
    if ({note_on, note_idx, half_period} !== {1'b1, 4'd9, 19'd56817} || pulses != 1 || drops != 0) begin
      bad++;
      $display("FAIL switch_final: got on=%b idx=%0d half=%0d pulses=%0d drops=%0d want 1/9/56817/1/0",
               note_on, note_idx, half_period, pulses, drops);
    end
  endtask

  task automatic test_release_all();
    int pulses = 0;
    do_reset();
    keys = 12'h800;
    repeat (24) step();
    total++;
    if ({note_on, note_idx, half_period} !== {1'b1, 4'd11, 19'd50618}) begin
      bad++;
      $display("FAIL release_active: got on=%b idx=%0d half=%0d want 1/11/50618", note_on, note_idx, half_period);
    end
    keys = 12'h000;
    for (int c = 0; c < 24; c++) begin
      step();
      total++;
      if ({note_on, note_idx, half_period, note_change} !== {exp_on, exp_idx, exp_half, exp_chg}) begin
        bad++;
        $display("FAIL release_model c=%0d: got %h want %h", c,
                 {note_on, note_idx, half_period, note_change}, {exp_on, exp_idx, exp_half, exp_chg});
      end
      if (note_change) pulses++;
    end
    total++;
    if ({note_on, note_idx, half_period} !== 24'h0 || pulses != 1) begin
      bad++;
      $display("FAIL release_final: got on=%b idx=%0d half=%0d pulses=%0d want 0/0/0/1",
               note_on, note_idx, half_period, pulses);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    keys = 12'h010;
    repeat (9) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    total++;
    if ({note_on, note_idx, half_period, note_change} !== 25'h0) begin
      bad++;
      $display("FAIL midreset_clear: got %h want 0", {note_on, note_idx, half_period, note_change});
    end
    for (int c = 0; c < 13; c++) begin
      step();
      total++;
      if (note_on !== (c == 12)) begin
        bad++;
        $display("FAIL midreset_restart c=%0d: note_on got %b want %b", c, note_on, (c == 12));
      end
    end
    total++;
    if ({note_idx, half_period, note_change} !== {4'd4, 19'd75842, 1'b1}) begin
      bad++;
      $display("FAIL midreset_note: got idx=%0d half=%0d chg=%b want 4/75842/1",
               note_idx, half_period, note_change);
    end
  endtask

  task automatic test_higher_press();
    int pulses = 0;
    do_reset();
    keys = 12'h010;
    repeat (24) step();
    keys = 12'h090;
    for (int c = 0; c < 24; c++) begin
      step();
      if (note_change) pulses++;
    end
    total++;
    if ({note_on, note_idx, half_period} !== {1'b1, 4'd4, 19'd75842} || pulses != 0) begin
      bad++;
      $display("FAIL higher_press: got on=%b idx=%0d half=%0d pulses=%0d want 1/4/75842/0",
               note_on, note_idx, half_period, pulses);
    end
  endtask

  task automatic test_random();
    int hold;
    do_reset();
    for (int seg = 0; seg < 120; seg++) begin
      case ($urandom_range(0, 3))
        0:       keys = 12'h000;
        1:       keys = 12'(1 << $urandom_range(0, 11));
        2:       keys = 12'($urandom) & 12'($urandom);
        default: keys = 12'($urandom);
      endcase
      if ($urandom_range(0, 29) == 0) rst = 1'b1;
      hold = int'($urandom_range(1, 24));
      for (int c = 0; c < hold; c++) begin
        step();
        rst = 1'b0;
        total++;
        if ({note_on, note_idx, half_period, note_change} !== {exp_on, exp_idx, exp_half, exp_chg}) begin
          bad++;
          $display("FAIL random_model seg=%0d c=%0d: got %h want %h", seg, c,
                   {note_on, note_idx, half_period, note_change}, {exp_on, exp_idx, exp_half, exp_chg});
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_held();
    test_glitch();
    test_switch();
    test_release_all();
    test_reset_mid();
    test_higher_press();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
